// File: rtl/pipeid_opnd.sv
// rtl/pipeid_opnd.sv - ID-stage operand unit: regfile, E/M forwarding, load-use and long-op interlocks
//
// Purpose:
//   Supplies the ID stage with forwarded source operands, branch-compare
//   flags and the global nostall signal. A small scoreboard tracks one
//   non-pipelined long-latency unit (mul/div) whose result is written back
//   LONG_LAT cycles after issue.
//
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   rs, rt, use_rs, use_rt    decoder source registers and read qualifiers
//   ewreg, em2reg, ern, ealu  EX-stage write-enable, load flag, dest, ALU result
//   mwreg, mm2reg, mrn,       MEM-stage write-enable, load flag, dest,
//   malu, mmo                 ALU result and memory read data
//   wwreg, wrn, wdi           WB write port
//   issue_long, long_rd       ID holds a long-latency op and its destination
//   a, b                      forwarded operands
//   fwda, fwdb                operand selects: 00 regfile, 01 ealu, 10 malu, 11 mmo
//   rsrtequ, a_zero, a_neg    compare flags on the forwarded operands
//   nostall                   0 freezes PC/IF-ID and bubbles ID/EX
//   long_busy                 long-op scoreboard occupied

module pipeid_opnd #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LONG_LAT = 4,
  parameter int CW       = 4
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic            use_rs,
  input  logic            use_rt,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic [AW-1:0]   ern,
  input  logic [XLEN-1:0] ealu,
  input  logic            mwreg,
  input  logic            mm2reg,
  input  logic [AW-1:0]   mrn,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mmo,
  input  logic            wwreg,
  input  logic [AW-1:0]   wrn,
  input  logic [XLEN-1:0] wdi,
  input  logic            issue_long,
  input  logic [AW-1:0]   long_rd,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb,
  output logic            rsrtequ,
  output logic            a_zero,
  output logic            a_neg,
  output logic            nostall,
  output logic            long_busy
);

  localparam int NREG = 1 << AW;

  // ------------------------------------------------------------------
  // Register file. Written on the falling edge so that a WB write and an
  // ID read of the same register in one cycle see the new value during
  // the second half of the cycle, in time for the ID/EX capture.
  // ------------------------------------------------------------------
  logic [XLEN-1:0] rf [NREG];

  always_ff @(negedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wwreg && (wrn != '0)) begin
      rf[wrn] <= wdi;
    end
  end

  logic [XLEN-1:0] qa;
  logic [XLEN-1:0] qb;

  // Entry 0 is never written, but the explicit zero keeps r0 hard-wired
  // independent of what the array holds.
  assign qa = (rs == '0) ? '0 : rf[rs];
  assign qb = (rt == '0) ? '0 : rf[rt];

  // ------------------------------------------------------------------
  // Forwarding selects. A load in EX has no data yet, so it is never a
  // forwarding source (that case is covered by the load-use stall).
  // EX is the younger producer and wins over MEM.
  // ------------------------------------------------------------------
  logic e_hit_a, e_hit_b, m_hit_a, m_hit_b;

  assign e_hit_a = ewreg && (ern != '0) && (ern == rs) && !em2reg;
  assign e_hit_b = ewreg && (ern != '0) && (ern == rt) && !em2reg;
  assign m_hit_a = mwreg && (mrn != '0) && (mrn == rs);
  assign m_hit_b = mwreg && (mrn != '0) && (mrn == rt);

  always_comb begin
    fwda = 2'b00;
    if (e_hit_a) begin
      fwda = 2'b01;
    end else if (m_hit_a) begin
      fwda = mm2reg ? 2'b11 : 2'b10;
    end
  end

  always_comb begin
    fwdb = 2'b00;
    if (e_hit_b) begin
      fwdb = 2'b01;
    end else if (m_hit_b) begin
      fwdb = mm2reg ? 2'b11 : 2'b10;
    end
  end

  always_comb begin
    a = qa;
    case (fwda)
      2'b01:   a = ealu;
      2'b10:   a = malu;
      2'b11:   a = mmo;
      default: a = qa;
    endcase
  end

  always_comb begin
    b = qb;
    case (fwdb)
      2'b01:   b = ealu;
      2'b10:   b = malu;
      2'b11:   b = mmo;
      default: b = qb;
    endcase
  end

  // ------------------------------------------------------------------
  // Branch-compare flags, straight off the forwarded operands.
  // ------------------------------------------------------------------
  assign rsrtequ = (a == b);
  assign a_zero  = (a == '0);
  assign a_neg   = a[XLEN-1];

  // ------------------------------------------------------------------
  // Long-op scoreboard. BUSY is exactly "cnt != 0"; the counter runs down
  // every cycle regardless of stalls because the unit itself never waits.
  // ------------------------------------------------------------------
  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_t;

  sb_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] busy_rn, busy_rn_nx;

  logic load_use_stall;
  logic raw_stall;
  logic struct_stall;

  assign load_use_stall = ewreg && em2reg && (ern != '0) &&
                          ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

  // busy_rn == 0 means the long op targets r0: occupancy only, no hazard.
  assign raw_stall = (cnt != '0) && (busy_rn != '0) &&
                     ((use_rs && (rs == busy_rn)) || (use_rt && (rt == busy_rn)));

  // Only one long op in flight; a new one waits until the counter is 0.
  assign struct_stall = issue_long && (cnt != '0);

  assign nostall   = ~(load_use_stall | raw_stall | struct_stall);
  assign long_busy = (cnt != '0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= SB_IDLE;
      cnt     <= '0;
      busy_rn <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      busy_rn <= busy_rn_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    busy_rn_nx = busy_rn;
    case (state)
      SB_IDLE: begin
        // A stalled instruction is not issued, so its long op must not load.
        if (issue_long && nostall) begin
          state_nx   = SB_BUSY;
          cnt_nx     = CW'(LONG_LAT);
          busy_rn_nx = long_rd;
        end
      end
      SB_BUSY: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx   = SB_IDLE;
          busy_rn_nx = '0;
        end
      end
      default: begin
        state_nx   = SB_IDLE;
        cnt_nx     = '0;
        busy_rn_nx = '0;
      end
    endcase
  end

endmodule
